// File: rtl/johnson_sequence_controller.sv
// Johnson (twisted-ring) counter sequencer: runs a programmed number of full
// rotations in either direction, with pause/abort, one-hot phase decode and busy/done flags.
module johnson_sequence_controller #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   rotations,
  input  logic               dir,
  input  logic               pause,
  input  logic               abort,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = $clog2(2*WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic             dir_r;
  logic [WIDTH-1:0] q_next;
  logic [IDX_W-1:0] ones;
  logic [IDX_W-1:0] trans;
  logic [IDX_W-1:0] idx;
  logic             illegal;

  assign q_next = dir_r ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};

  // Legal Johnson words have at most one boundary between a run of ones and zeros.
  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < WIDTH; i++)     ones  = ones + IDX_W'(q[i]);
    for (int i = 0; i < WIDTH - 1; i++) trans = trans + IDX_W'(q[i] ^ q[i+1]);
  end

  assign illegal = (trans > IDX_W'(1));
  // MSB set: index = WIDTH + zeros = 2*WIDTH - ones (modulo the index width).
  assign idx     = q[WIDTH-1] ? IDX_W'(2*WIDTH) - ones : ones;

  always_comb begin
    phase = '0;
    if (!illegal) phase[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      remaining <= '0;
      dir_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (rotations != '0) begin
              state     <= RUN;
              remaining <= rotations;
              dir_r     <= dir;
              busy      <= 1'b1;
              q         <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            q         <= '0;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (pause) begin
            state <= PAUSE;
          end else if (illegal) begin
            q <= '0;
          end else begin
            q <= q_next;
            if (q_next == '0 && remaining != '0) begin
              remaining <= remaining - CNT_W'(1);
              if (remaining == CNT_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (abort) begin
            state     <= IDLE;
            q         <= '0;
            remaining <= '0;
            busy      <= 1'b0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_sequence_controller.sv
// Scoreboard bench: a phase-index model predicts {q,phase,busy,done} per edge;
// a monitor pops and compares one entry after every rising edge.
module tb_johnson_sequence_controller;
  localparam int W = 4;
  localparam int CW = 8;
  localparam int NPH = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] rotations = '0;
  logic          dir = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  q;
  logic [NPH-1:0] phase;
  logic          busy;
  logic          done;

  johnson_sequence_controller #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .rotations(rotations), .dir(dir),
    .pause(pause), .abort(abort), .q(q), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [W+NPH+1:0] exp_q[$];
  logic rst_lvl = 1'b1;

  // Model: position on the 2W-phase ring, rotations left, run/pause flags.
  int m_idx = 0, m_rem = 0;
  bit m_busy = 0, m_paused = 0, m_dir = 0, m_done = 0;

  function automatic logic [W-1:0] q_of(int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    return W'(v);
  endfunction

  function automatic logic [W+NPH+1:0] expected();
    logic [NPH-1:0] ph;
    ph = NPH'(1) << m_idx;
    return {q_of(m_idx), ph, logic'(m_busy), logic'(m_done)};
  endfunction

  task automatic model_reset();
    m_idx = 0; m_rem = 0; m_busy = 0; m_paused = 0; m_dir = 0; m_done = 0;
  endtask

  task automatic model_edge(bit s, int r, bit d, bit p, bit a);
    bit dn = 0;
    if (rst_lvl) begin model_reset(); return; end
    if (!m_busy) begin
      if (s) begin
        if (r != 0) begin m_busy = 1; m_rem = r; m_dir = d; m_idx = 0; m_paused = 0; end
        else dn = 1;
      end
    end else if (a) begin
      m_busy = 0; m_idx = 0; m_rem = 0; m_paused = 0;
    end else if (m_paused) begin
      if (!p) m_paused = 0;
    end else if (p) begin
      m_paused = 1;
    end else begin
      m_idx = m_dir ? (m_idx + NPH - 1) % NPH : (m_idx + 1) % NPH;
      if (m_idx == 0) begin
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; dn = 1; end
      end
    end
    m_done = dn;
  endtask

  task automatic step(bit s, int r, bit d, bit p, bit a);
    @(negedge clk);
    reset = rst_lvl; start = s; rotations = CW'(r); dir = d; pause = p; abort = a;
    model_edge(s, r, d, p, a);
    exp_q.push_back(expected());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_now(string name);
    logic [W+NPH+1:0] got, want;
    got = {q, phase, busy, done};
    want = expected();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got q=%b phase=%h busy=%b done=%b, want q=%b phase=%h busy=%b done=%b",
               name, got[W+NPH+1:NPH+2], got[NPH+1:2], got[1], got[0],
               want[W+NPH+1:NPH+2], want[NPH+1:2], want[1], want[0]);
    end
  endtask

  // Monitor: compares what the DUT presents after each edge against the queue.
  initial begin
    logic [W+NPH+1:0] got, want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got = {q, phase, busy, done};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL cycle@%0t: got q=%b phase=%h busy=%b done=%b, want q=%b phase=%h busy=%b done=%b",
                   $time, got[W+NPH+1:NPH+2], got[NPH+1:2], got[1], got[0],
                   want[W+NPH+1:NPH+2], want[NPH+1:2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    #1 check_now("reset_initial");
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst_lvl = 0;
    idle(2);

    // rotations=2 dir=0; start held high with changing rotations/dir mid-run
    step(1, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 7, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 9, 1, 0, 0);
    idle(2);

    // rotations=1 dir=1
    step(1, 1, 1, 0, 0);
    idle(10);

    // rotations=3, pause 3 cycles at q=0111
    step(1, 3, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    idle(24);

    // abort at q=1110 in RUN, then new start
    step(1, 2, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 0, 1);
    idle(1);
    step(1, 1, 0, 0, 0);
    idle(10);

    // abort while paused at q=1110
    step(1, 2, 0, 0, 0);
    idle(5);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    idle(1);

    // rotations=0, then back-to-back start in the done cycle
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    idle(8);
    step(1, 1, 1, 0, 0);
    idle(3);

    // asynchronous reset mid-run at q=0111
    step(1, 2, 0, 0, 0);
    idle(3);
    @(posedge clk);
    #3 rst_lvl = 1; reset = 1'b1;
    model_reset();
    #1 check_now("reset_async");
    step(0, 0, 0, 0, 0);
    rst_lvl = 0;
    idle(2);

    // maximum rotation count, no wrap of the remaining counter
    step(1, 255, 1, 0, 0);
    idle(2 * W * 255 + 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit s, d, p, a;
      int r;
      s = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 3);
      d = 1'($urandom_range(0, 1));
      p = ($urandom_range(0, 7) == 0);
      a = !s && ($urandom_range(0, 39) == 0);
      step(s, r, d, p, a);
    end

    // drain with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
